// File: rtl/costas_pkg.sv
// -----------------------------------------------------------------------------
// costas_pkg
// Shared definitions for the Costas lock detector:
//   - DEFAULT_DW   : default width of the signed I/Q arm samples
//   - lock_state_t : lock FSM encoding (SEARCH/VERIFY/LOCKED/HOLD), whose
//                    numeric values are visible on the lock_state debug port
// -----------------------------------------------------------------------------
package costas_pkg;

    localparam int DEFAULT_DW = 14;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        HOLD   = 2'd3
    } lock_state_t;

endpackage

// File: rtl/costas_iad_acc.sv
// -----------------------------------------------------------------------------
// costas_iad_acc
// Saturating integrate-and-dump accumulator.
//   SIGNED_MODE=0 : sample is a non-negative magnitude, sum saturates at all-ones
//   SIGNED_MODE=1 : sample is two's complement, sum saturates at signed max/min
// Ports:
//   clock        in   rising-edge clock
//   resest       in   synchronous active-low reset
//   sample_valid in   add sample this cycle
//   last_sample  in   this valid sample closes the window (dump)
//   sample       in   DW-bit sample
//   total        out  saturated running sum including the current sample
//   result       out  total of the last completed window (held between dumps)
// -----------------------------------------------------------------------------
module costas_iad_acc #(
    parameter int DW          = 14,
    parameter int ACC_W       = 26,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic             clock,
    input  logic             resest,
    input  logic             sample_valid,
    input  logic             last_sample,
    input  logic [DW-1:0]    sample,
    output logic [ACC_W-1:0] total,
    output logic [ACC_W-1:0] result
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   sample_ext;
    logic [ACC_W:0]   sum;

    // One guard bit above the accumulator width detects overflow.
    assign sample_ext = {{(ACC_W+1-DW){sample[DW-1]}}, sample};

    generate
        if (SIGNED_MODE) begin : g_signed
            assign sum = {acc_reg[ACC_W-1], acc_reg} + sample_ext;
            // Guard bit and MSB disagree only on signed overflow; the guard
            // bit then carries the true sign of the result.
            always_comb begin
                total = sum[ACC_W-1:0];
                if (sum[ACC_W] != sum[ACC_W-1])
                    total = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin : g_unsigned
            assign sum = {1'b0, acc_reg} + sample_ext;
            assign total = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end
    endgenerate

    // On the closing sample the total goes straight to the result and the
    // accumulator restarts from 0, so the next sample starts a fresh window.
    always_ff @(posedge clock) begin
        if (!resest) begin
            acc_reg <= '0;
            result  <= '0;
        end else if (sample_valid) begin
            if (last_sample) begin
                result  <= total;
                acc_reg <= '0;
            end else begin
                acc_reg <= total;
            end
        end
    end

endmodule

// File: rtl/costas_lock_detect.sv
// -----------------------------------------------------------------------------
// costas_lock_detect
// Integrate-and-dump over fixed windows of the Costas loop's filtered I/Q arm
// outputs, giving a hard data decision per window and a hysteretic lock flag.
// Ports:
//   clock       in   system clock (rising edge)
//   resest      in   synchronous active-low reset
//   i_in, q_in  in   signed filtered I/Q arm samples
//   in_valid    in   samples valid this cycle
//   dump_valid  out  one-cycle pulse when window results update
//   i_abs_acc   out  sum of |I| over last window
//   q_abs_acc   out  sum of |Q| over last window
//   data_bit    out  sign of signed I sum over last window (1 = negative)
//   lock        out  carrier lock flag (LOCKED or HOLD)
//   lock_state  out  lock FSM state, debug
// -----------------------------------------------------------------------------
module costas_lock_detect
    import costas_pkg::*;
#(
    parameter int DW          = DEFAULT_DW,
    parameter int ACC_W       = 26,
    parameter int DUMP_LEN    = 1500,
    parameter int RATIO_SHIFT = 2,
    parameter int MIN_ENERGY  = 4096,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 2
) (
    input  logic             clock,
    input  logic             resest,
    input  logic [DW-1:0]    i_in,
    input  logic [DW-1:0]    q_in,
    input  logic             in_valid,
    output logic             dump_valid,
    output logic [ACC_W-1:0] i_abs_acc,
    output logic [ACC_W-1:0] q_abs_acc,
    output logic             data_bit,
    output logic             lock,
    output logic [1:0]       lock_state
);

    localparam int          CNT_W      = $clog2(DUMP_LEN);
    localparam int          SH_W       = ACC_W + RATIO_SHIFT;
    localparam logic [2:0]  LOCK_TGT   = 3'(LOCK_CNT);
    localparam logic [2:0]  UNLOCK_TGT = 3'(UNLOCK_CNT);

    // Magnitude with the most negative code folded onto the positive max.
    function automatic logic [DW-1:0] sat_abs(input logic [DW-1:0] x);
        if (!x[DW-1])
            return x;
        if (x == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
        return -x;
    endfunction

    logic [CNT_W-1:0] count_reg;
    logic             last_sample;
    logic             dump_valid_reg;

    // Accumulator lanes: 0 = |I|, 1 = |Q|, 2 = signed I.
    logic [DW-1:0]    acc_sample [3];
    logic [ACC_W-1:0] acc_total  [3];
    logic [ACC_W-1:0] acc_result [3];

    assign acc_sample[0] = sat_abs(i_in);
    assign acc_sample[1] = sat_abs(q_in);
    assign acc_sample[2] = i_in;

    assign last_sample = in_valid && (count_reg == CNT_W'(DUMP_LEN - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_acc
            costas_iad_acc #(
                .DW          (DW),
                .ACC_W       (ACC_W),
                .SIGNED_MODE (gi == 2)
            ) u_acc (
                .clock        (clock),
                .resest       (resest),
                .sample_valid (in_valid),
                .last_sample  (last_sample),
                .sample       (acc_sample[gi]),
                .total        (acc_total[gi]),
                .result       (acc_result[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resest) begin
            count_reg      <= '0;
            dump_valid_reg <= 1'b0;
        end else begin
            dump_valid_reg <= last_sample;
            if (in_valid)
                count_reg <= last_sample ? '0 : count_reg + 1'b1;
        end
    end

    // Window quality uses the running totals that include the closing sample,
    // so the FSM moves on the same edge that registers the window results.
    logic [SH_W-1:0] i_wide;
    logic [SH_W-1:0] q_scaled;
    logic            good;

    assign i_wide   = SH_W'(acc_total[0]);
    assign q_scaled = SH_W'(acc_total[1]) << RATIO_SHIFT;
    assign good     = (i_wide >= q_scaled) && (acc_total[0] >= ACC_W'(MIN_ENERGY));

    lock_state_t state_reg, state_next;
    logic [2:0]  hits_reg, hits_next;
    logic [2:0]  miss_reg, miss_next;
    logic        lock_reg, lock_next;
    logic [2:0]  hits_inc, miss_inc;

    assign hits_inc = hits_reg + 3'd1;
    assign miss_inc = miss_reg + 3'd1;

    always_ff @(posedge clock) begin
        if (!resest) begin
            state_reg <= SEARCH;
            hits_reg  <= '0;
            miss_reg  <= '0;
            lock_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hits_reg  <= hits_next;
            miss_reg  <= miss_next;
            lock_reg  <= lock_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hits_next  = hits_reg;
        miss_next  = miss_reg;
        if (last_sample) begin
            case (state_reg)
                SEARCH: begin
                    if (good) begin
                        if (LOCK_TGT <= 3'd1) begin
                            state_next = LOCKED;
                            hits_next  = '0;
                        end else begin
                            state_next = VERIFY;
                            hits_next  = 3'd1;
                        end
                    end
                end
                VERIFY: begin
                    if (!good) begin
                        state_next = SEARCH;
                        hits_next  = '0;
                    end else if (hits_inc >= LOCK_TGT) begin
                        state_next = LOCKED;
                        hits_next  = '0;
                    end else begin
                        hits_next  = hits_inc;
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        if (UNLOCK_TGT <= 3'd1) begin
                            state_next = SEARCH;
                            miss_next  = '0;
                        end else begin
                            state_next = HOLD;
                            miss_next  = 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (good) begin
                        state_next = LOCKED;
                        miss_next  = '0;
                    end else if (miss_inc >= UNLOCK_TGT) begin
                        state_next = SEARCH;
                        miss_next  = '0;
                        hits_next  = '0;
                    end else begin
                        miss_next  = miss_inc;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    hits_next  = '0;
                    miss_next  = '0;
                end
            endcase
        end
        lock_next = (state_next == LOCKED) || (state_next == HOLD);
    end

    assign dump_valid = dump_valid_reg;
    assign i_abs_acc  = acc_result[0];
    assign q_abs_acc  = acc_result[1];
    assign data_bit   = acc_result[2][ACC_W-1];
    assign lock       = lock_reg;
    assign lock_state = state_reg;

endmodule

// File: tb/tb_costas_lock_detect.sv
// -----------------------------------------------------------------------------
// tb_costas_lock_detect
// Directed stimulus for costas_lock_detect with hand-computed window totals,
// FSM states and window lengths.
// -----------------------------------------------------------------------------
module tb_costas_lock_detect;

    localparam int DW    = 14;
    localparam int ACC_W = 26;

    logic             clock = 1'b0;
    logic             resest;
    logic [DW-1:0]    i_in;
    logic [DW-1:0]    q_in;
    logic             in_valid;
    logic             dump_valid;
    logic [ACC_W-1:0] i_abs_acc;
    logic [ACC_W-1:0] q_abs_acc;
    logic             data_bit;
    logic             lock;
    logic [1:0]       lock_state;

    int checks = 0;
    int errors = 0;
    bit toggle_mode  = 1'b0;
    bit watch_lock   = 1'b0;
    bit lock_dropped = 1'b0;

    costas_lock_detect dut (
        .clock      (clock),
        .resest     (resest),
        .i_in       (i_in),
        .q_in       (q_in),
        .in_valid   (in_valid),
        .dump_valid (dump_valid),
        .i_abs_acc  (i_abs_acc),
        .q_abs_acc  (q_abs_acc),
        .data_bit   (data_bit),
        .lock       (lock),
        .lock_state (lock_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advances one clock at a time (sampling 1 time unit after the edge) until
    // dump_valid is seen or the budget runs out; returns edges elapsed.
    task automatic wait_dump(output int cyc);
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
            if (watch_lock && !lock)
                lock_dropped = 1'b1;
            if (toggle_mode)
                in_valid = ~in_valid;
        end while (!dump_valid && cyc < 4000);
    endtask

    task automatic window(input string tag, input int exp_cyc,
                          input int exp_i, input int exp_q, input bit exp_bit,
                          input bit exp_lock, input int exp_state);
        int cyc;
        wait_dump(cyc);
        $display("%s: cycles=%0d i_abs=%0d q_abs=%0d data_bit=%0b lock=%0b state=%0d",
                 tag, cyc, i_abs_acc, q_abs_acc, data_bit, lock, lock_state);
        chk({tag, ".cycles"}, cyc, exp_cyc);
        chk({tag, ".i_abs"}, i_abs_acc, exp_i);
        chk({tag, ".q_abs"}, q_abs_acc, exp_q);
        chk({tag, ".data_bit"}, data_bit, exp_bit);
        chk({tag, ".lock"}, lock, exp_lock);
        chk({tag, ".state"}, lock_state, exp_state);
    endtask

    initial begin
        // 1. Reset held for 3 clocks with in_valid asserted.
        resest   = 1'b0;
        in_valid = 1'b1;
        i_in     = 14'd4000;
        q_in     = 14'd100;
        repeat (3) @(posedge clock);
        #1;
        $display("reset: dump_valid=%0b lock=%0b state=%0d", dump_valid, lock, lock_state);
        chk("reset.dump_valid", dump_valid, 0);
        chk("reset.i_abs", i_abs_acc, 0);
        chk("reset.q_abs", q_abs_acc, 0);
        chk("reset.data_bit", data_bit, 0);
        chk("reset.lock", lock, 0);
        chk("reset.state", lock_state, 0);
        resest = 1'b1;

        // 2. Lock acquire: 4000*1500 and 100*1500, lock at the 4th dump.
        window("acq1", 1500, 6000000, 150000, 1'b0, 1'b0, 1);
        window("acq2", 1500, 6000000, 150000, 1'b0, 1'b0, 1);
        window("acq3", 1500, 6000000, 150000, 1'b0, 1'b0, 1);
        window("acq4", 1500, 6000000, 150000, 1'b0, 1'b1, 2);

        // 3. Lock loss: I=100, Q=4000 fails the ratio test twice.
        i_in = 14'd100;
        q_in = 14'd4000;
        window("loss1", 1500, 150000, 6000000, 1'b0, 1'b1, 3);
        window("loss2", 1500, 150000, 6000000, 1'b0, 1'b0, 0);

        // 4. Hysteresis: reacquire, one bad window, then good again.
        i_in = 14'd4000;
        q_in = 14'd100;
        window("reacq1", 1500, 6000000, 150000, 1'b0, 1'b0, 1);
        window("reacq2", 1500, 6000000, 150000, 1'b0, 1'b0, 1);
        window("reacq3", 1500, 6000000, 150000, 1'b0, 1'b0, 1);
        window("reacq4", 1500, 6000000, 150000, 1'b0, 1'b1, 2);
        watch_lock = 1'b1;
        i_in = 14'd100;
        q_in = 14'd4000;
        window("hyst_bad", 1500, 150000, 6000000, 1'b0, 1'b1, 3);
        i_in = 14'd4000;
        q_in = 14'd100;
        window("hyst_good1", 1500, 6000000, 150000, 1'b0, 1'b1, 2);
        window("hyst_good2", 1500, 6000000, 150000, 1'b0, 1'b1, 2);
        watch_lock = 1'b0;
        chk("hyst.lock_dropped", lock_dropped, 0);

        // 5. Saturated |-8192| = 8191, valid on alternate cycles: the 1500th
        // sample lands on edge 2999; signed sum -12288000 is negative.
        i_in        = 14'h2000;
        q_in        = 14'd0;
        toggle_mode = 1'b1;
        window("sat", 2999, 12286500, 0, 1'b1, 1'b1, 2);
        toggle_mode = 1'b0;

        // 6. Reset after 700 samples of a window, then a clean window.
        in_valid = 1'b1;
        i_in     = 14'd4000;
        q_in     = 14'd100;
        repeat (700) @(posedge clock);
        #1;
        resest = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        $display("midreset: dump_valid=%0b lock=%0b state=%0d", dump_valid, lock, lock_state);
        chk("midreset.lock", lock, 0);
        chk("midreset.state", lock_state, 0);
        chk("midreset.data_bit", data_bit, 0);
        chk("midreset.i_abs", i_abs_acc, 0);
        resest = 1'b1;
        window("post_reset", 1500, 6000000, 150000, 1'b0, 1'b0, 1);

        // dump_valid is a single-cycle pulse; results hold afterwards.
        @(posedge clock);
        #1;
        chk("pulse.dump_valid", dump_valid, 0);
        chk("pulse.i_abs_hold", i_abs_acc, 6000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
